// File: rtl/store_buffer_pkg.sv
// Shared types and default sizes for the store buffer slice.
package store_buffer_pkg;

    localparam int STORE_BUFFER_WIDTH = 3;
    localparam int MEM_WIDTH          = 17;

    typedef enum logic [1:0] {
        SB_FREE   = 2'd0,
        SB_EXEC   = 2'd1,
        SB_COMMIT = 2'd2
    } sb_state;

    function automatic logic sb_live(input logic [1:0] s);
        return s != SB_FREE;
    endfunction

endpackage

// File: rtl/store_buffer_forward.sv
// Age-ordered store-to-load forwarding: the youngest live entry whose address
// matches load_addr supplies the data.
module store_buffer_forward #(
    parameter int STORE_BUFFER_WIDTH = 3,
    parameter int MEM_WIDTH          = 17
) (
    input  logic [2*(2**STORE_BUFFER_WIDTH)-1:0]         states,
    input  logic [MEM_WIDTH*(2**STORE_BUFFER_WIDTH)-1:0] addrs,
    input  logic [32*(2**STORE_BUFFER_WIDTH)-1:0]        datas,
    input  logic [STORE_BUFFER_WIDTH-1:0]                alloc_ptr,
    input  logic [MEM_WIDTH-1:0]                         load_addr,
    output logic                                         hit,
    output logic [31:0]                                  data
);
    import store_buffer_pkg::*;

    localparam int N = 2**STORE_BUFFER_WIDTH;

    logic [STORE_BUFFER_WIDTH-1:0] idx;

    // Walk from oldest (distance N back from alloc_ptr) to youngest so that
    // later, younger matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int d = N; d >= 1; d--) begin
            idx = alloc_ptr - STORE_BUFFER_WIDTH'(d);
            if (sb_live(states[2*int'(idx) +: 2]) &&
                addrs[MEM_WIDTH*int'(idx) +: MEM_WIDTH] == load_addr) begin
                hit  = 1'b1;
                data = datas[32*int'(idx) +: 32];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Ring of executed stores: entries are written on exec, marked committed by the
// commit ring, drained to data memory in order, and discarded on flush if uncommitted.
module store_buffer #(
    parameter int STORE_BUFFER_WIDTH = store_buffer_pkg::STORE_BUFFER_WIDTH,
    parameter int MEM_WIDTH          = store_buffer_pkg::MEM_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    // valid/ready: a transfer happens on a rising edge where both are high;
    // valid may not depend on ready, and ready never depends on valid.
    input  logic                 exec_req_valid,
    output logic                 exec_req_ready,
    input  logic [MEM_WIDTH-1:0] exec_addr,
    input  logic [31:0]          exec_data,
    input  logic                 commit_req_valid,
    output logic                 commit_req_ready,
    output logic                 mem_we,
    output logic [MEM_WIDTH-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [MEM_WIDTH-1:0] load_addr,
    output logic                 load_hit,
    output logic [31:0]          load_data,
    output logic                 empty
);
    import store_buffer_pkg::*;

    localparam int N = 2**STORE_BUFFER_WIDTH;

    sb_state                       state_q [N];
    sb_state                       state_d [N];
    logic [MEM_WIDTH-1:0]          addr_q  [N];
    logic [31:0]                   data_q  [N];

    logic [STORE_BUFFER_WIDTH-1:0] drain_ptr;
    logic [STORE_BUFFER_WIDTH-1:0] commit_ptr;
    logic [STORE_BUFFER_WIDTH-1:0] alloc_ptr;
    logic [STORE_BUFFER_WIDTH-1:0] commit_next;
    logic [STORE_BUFFER_WIDTH-1:0] flush_span;
    logic [STORE_BUFFER_WIDTH-1:0] flush_off;
    logic                          exec_fire;
    logic                          commit_fire;

    logic [2*N-1:0]                states_flat;
    logic [MEM_WIDTH*N-1:0]        addrs_flat;
    logic [32*N-1:0]               datas_flat;

    assign exec_req_ready   = (alloc_ptr + 1'b1 != drain_ptr) && !flush;
    assign commit_req_ready = commit_ptr != alloc_ptr;
    assign exec_fire        = exec_req_valid && exec_req_ready;
    assign commit_fire      = commit_req_valid && commit_req_ready;
    assign commit_next      = commit_fire ? commit_ptr + 1'b1 : commit_ptr;

    assign mem_we    = drain_ptr != commit_ptr;
    assign mem_addr  = addr_q[drain_ptr];
    assign mem_wdata = data_q[drain_ptr];
    assign empty     = drain_ptr == alloc_ptr;

    // Drain, commit and exec/flush touch disjoint entries, so their updates never collide.
    always_comb begin
        flush_span = alloc_ptr - commit_next;
        flush_off  = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
        end
        if (mem_we) begin
            state_d[drain_ptr] = SB_FREE;
        end
        if (commit_fire) begin
            state_d[commit_ptr] = SB_COMMIT;
        end
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                flush_off = STORE_BUFFER_WIDTH'(i) - commit_next;
                if (flush_off < flush_span) begin
                    state_d[i] = SB_FREE;
                end
            end
        end else if (exec_fire) begin
            state_d[alloc_ptr] = SB_EXEC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_ptr  <= '0;
            commit_ptr <= '0;
            alloc_ptr  <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= SB_FREE;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
            end
            if (mem_we) begin
                drain_ptr <= drain_ptr + 1'b1;
            end
            commit_ptr <= commit_next;
            if (flush) begin
                alloc_ptr <= commit_next;
            end else if (exec_fire) begin
                alloc_ptr <= alloc_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: a FREE state hides stale contents.
    always_ff @(posedge clk) begin
        if (!reset && exec_fire) begin
            addr_q[alloc_ptr] <= exec_addr;
            data_q[alloc_ptr] <= exec_data;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign states_flat[2*g +: 2]                 = state_q[g];
        assign addrs_flat[MEM_WIDTH*g +: MEM_WIDTH]  = addr_q[g];
        assign datas_flat[32*g +: 32]                = data_q[g];
    end

    store_buffer_forward #(
        .STORE_BUFFER_WIDTH (STORE_BUFFER_WIDTH),
        .MEM_WIDTH          (MEM_WIDTH)
    ) u_forward (
        .states    (states_flat),
        .addrs     (addrs_flat),
        .datas     (datas_flat),
        .alloc_ptr (alloc_ptr),
        .load_addr (load_addr),
        .hit       (load_hit),
        .data      (load_data)
    );

endmodule

// File: doc/store_buffer.md
# store_buffer

Holds executed stores between the store unit and data memory so memory is written only after the owning `sw` commits. Sits beside `commit_ring` and consumes its `commit_req_sw` handshake. Drains committed stores to data memory one per cycle, in program order. Forwards the youngest matching buffered store to loads, and discards uncommitted stores on flush.

## Interface
- `STORE_BUFFER_WIDTH`, default 3: log2 entry count; capacity is 2**W-1 usable entries.
- `MEM_WIDTH`, default 17: word-address width of data memory.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `flush`  in  1  misprediction flush, synchronous; discards all uncommitted entries.
- `exec_req`  req_if slave  -  executed store from the store unit, in program order; ready out.
- `exec_addr`  in  MEM_WIDTH  store word address, sampled on the exec handshake.
- `exec_data`  in  32  store data, sampled on the exec handshake.
- `commit_req`  req_if slave  -  connected to `commit_ring.commit_req_sw`; ready out.
- `mem_we`  out  1  data-memory write enable; memory always accepts.
- `mem_addr`  out  MEM_WIDTH  write address.
- `mem_wdata`  out  32  write data.
- `load_addr`  in  MEM_WIDTH  load lookup address.
- `load_hit`  out  1  a buffered store matches `load_addr`.
- `load_data`  out  32  data of the youngest matching store.
- `empty`  out  1  no entries held in any state.

## Operation
- Each entry has a state: `SB_FREE`, `SB_EXEC` (executed, not committed) or `SB_COMMIT` (committed, awaiting drain). Each entry also holds addr and data.
- Three W-bit wrapping pointers, in order drain ≤ commit ≤ alloc around the ring:
  - `drain_ptr`: oldest committed entry.
  - `commit_ptr`: oldest uncommitted entry.
  - `alloc_ptr`: next free entry.
- `exec_req.ready` = (alloc_ptr+1 != drain_ptr) && !flush.
  - Exec handshake: write addr/data at alloc_ptr, state ← SB_EXEC, alloc_ptr+1.
- `commit_req.ready` = commit_ptr != alloc_ptr, from registered state only; no same-cycle bypass from exec.
  - Commit handshake: state[commit_ptr] ← SB_COMMIT, commit_ptr+1.
- `mem_we` = drain_ptr != commit_ptr; `mem_addr`/`mem_wdata` come from entry[drain_ptr].
  - Every cycle with mem_we high: state ← SB_FREE, drain_ptr+1.
- Forwarding is combinational over entries in SB_EXEC or SB_COMMIT with addr == load_addr. The youngest match wins, by distance back from alloc_ptr.
  - No match gives load_hit=0, load_data=0.
- `flush`: alloc_ptr ← commit_ptr after the same-cycle commit is applied. Entries between them ← SB_FREE; committed entries keep draining.
- Exec, commit and drain may all occur in the same cycle, on distinct entries.
- Wrap-around: all pointers are modulo 2**W. Full is alloc_ptr+1 == drain_ptr.
- `commit_req.valid` while commit_ptr == alloc_ptr: ready stays low and the commit ring waits. Stores must have executed before commit.

## Timing
- Reset: all pointers 0, all entries SB_FREE. Outputs: exec_req.ready=1, commit_req.ready=0, mem_we=0, load_hit=0, empty=1. Reset overrides flush and all handshakes.
- Exec at edge t: the entry is visible to forwarding and commit_req.ready in cycle t+1.
- Commit at edge t: the write appears on the mem port in cycle t+1 at the earliest (one cycle later per older committed entry).
- Drain throughput: one store per cycle.
- Flush at edge t: exec_req.ready is low during cycle t. Flushed entries stop forwarding in t+1.
- `empty` = drain_ptr == alloc_ptr, combinational from registers.

## Structure
- Shared package / `common.vh` holds:
  - `STORE_BUFFER_WIDTH` and `MEM_WIDTH`.
  - The typedef `sb_state` enum {SB_FREE, SB_EXEC, SB_COMMIT}.
  - The `req_if` interface already used by `commit_ring`.
- Sub-module `store_buffer_forward` implements the age-ordered priority match. Inputs: states, addrs, datas, alloc_ptr, load_addr. Outputs: hit, data.

## Test plan
- Reset, then exec (addr 0x10, data 0xAAAA) at cycle 1 and commit at cycle 3 → commit ready at cycle 2. mem_we=1, addr 0x10, wdata 0xAAAA in cycle 4; empty=1 in cycle 5.
- Exec 7 stores with no commit → exec_req.ready=0 after the 7th. Commit+drain one → ready=1 again, with pointers wrapped past 7.
- Exec 0x20←1 then 0x20←2, load_addr=0x20 → load_hit=1, load_data=2. load_addr=0x21 → load_hit=0.
- Exec 3 stores, commit 1, flush together with commit 2 → stores 1 and 2 drain to memory. Store 3 is never written and stops forwarding; empty=1 afterwards.
- Exec, commit and drain in the same cycle with one entry in each state → all three pointers advance by 1 and no entry is corrupted.
- Reset asserted while 3 committed stores are pending → mem_we=0 next cycle and empty=1.
